rrd_stage: RTL

Register-read stage of the in-order issue path: sits between decode and execute, drives the two register-file read ports, and tracks in-flight destinations in a busy-bit scoreboard. It holds one decoded instruction until its sources are available, optionally forwarding write-port data, then registers operands and payload into a single output slot toward execute over a valid/ready handshake.

---
 rtl/rrd_pkg.sv | 29 ++
 rtl/rrd_scoreboard.sv | 48 ++++
 rtl/rrd_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rrd_pkg.sv
// Shared types and constants for the register-read stage: hold-entry layout,
// register-file geometry and the x0 index.
package rrd_pkg;

  localparam int S_INDEX         = 5;
  localparam int S_WIDTH         = 32;
  localparam int NUM_WRITE_PORTS = 3;
  localparam int S_PAYLOAD       = 32;
  localparam int NUM_REGS        = 2 ** S_INDEX;

  localparam logic [S_INDEX-1:0] X0 = '0;

  typedef struct packed {
    logic                 valid;
    logic [S_INDEX-1:0]   rs1;
    logic [S_INDEX-1:0]   rs2;
    logic [S_INDEX-1:0]   rd;
    logic                 use_rs1;
    logic                 use_rs2;
    logic                 wr_rd;
    logic [S_PAYLOAD-1:0] payload;
  } rrd_entry_t;

  // A register reference only matters if it is used and is not the hardwired zero.
  function automatic logic reg_live(input logic used, input logic [S_INDEX-1:0] idx);
    return used && (idx != X0);
  endfunction

endpackage

// File: rtl/rrd_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set on issue,
// cleared by writeback strobes; x0 is never busy and set beats clear.
module rrd_scoreboard
  import rrd_pkg::*;
#(
  parameter int s_index         = S_INDEX,
  parameter int num_write_ports = NUM_WRITE_PORTS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      set,
  input  logic [s_index-1:0]                        set_idx,
  input  logic [num_write_ports-1:0]                clr,
  input  logic [num_write_ports-1:0][s_index-1:0]   clr_idx,
  input  logic [s_index-1:0]                        q_rs1,
  input  logic [s_index-1:0]                        q_rs2,
  input  logic [s_index-1:0]                        q_rd,
  output logic                                      busy_rs1,
  output logic                                      busy_rs2,
  output logic                                      busy_rd
);

  localparam int num_regs = 2 ** s_index;

  logic [num_regs-1:0] busy;
  logic [num_regs-1:0] busy_nxt;

  always_comb begin
    // NOTE: assigning the full default first means no path leaves busy_nxt unassigned, so no latch.
    busy_nxt = busy;
    for (int i = 0; i < num_write_ports; i++) begin
      if (clr[i]) busy_nxt[clr_idx[i]] = 1'b0;
    end
    if (set) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: non-blocking update; the busy vector is control state, so unlike a data array it must be reset.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_rs1 = busy[q_rs1];
  assign busy_rs2 = busy[q_rs2];
  assign busy_rd  = busy[q_rd];

endmodule

// File: rtl/rrd_stage.sv
// Register-read stage: one-entry hold register, scoreboard interlock and a
// registered output slot toward execute. Define RRD_BYPASS_EN for writeback forwarding.
module rrd_stage
  import rrd_pkg::*;
#(
  parameter int s_index         = S_INDEX,
  parameter int s_width         = S_WIDTH,
  parameter int num_write_ports = NUM_WRITE_PORTS,
  parameter int s_payload       = S_PAYLOAD
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [s_index-1:0]                      in_rs1,
  input  logic [s_index-1:0]                      in_rs2,
  input  logic [s_index-1:0]                      in_rd,
  input  logic                                    in_use_rs1,
  input  logic                                    in_use_rs2,
  input  logic                                    in_wr_rd,
  input  logic [s_payload-1:0]                    in_payload,
  output logic [1:0][s_index-1:0]                 rf_src,
  input  logic [1:0][s_width-1:0]                 rf_out,
  input  logic [num_write_ports-1:0]              wb_ld,
  input  logic [num_write_ports-1:0][s_index-1:0] wb_dest,
  input  logic [num_write_ports-1:0][s_width-1:0] wb_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [s_width-1:0]                      out_op1,
  output logic [s_width-1:0]                      out_op2,
  output logic [s_index-1:0]                      out_rd,
  output logic                                    out_wr_rd,
  output logic [s_payload-1:0]                    out_payload
);

  rrd_entry_t         hold;
  logic               busy_rs1, busy_rs2, busy_rd;
  logic               live1, live2, hit1, hit2, rdy1, rdy2, waw, issue;
  logic [s_width-1:0] byp1, byp2, op1, op2;

  assign rf_src[0] = hold.rs1;
  assign rf_src[1] = hold.rs2;

  assign live1 = reg_live(hold.use_rs1, hold.rs1);
  assign live2 = reg_live(hold.use_rs2, hold.rs2);

`ifdef RRD_BYPASS_EN
  // Ascending scan so the highest-index matching port wins, like the register file.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    byp1 = '0;
    byp2 = '0;
    for (int i = 0; i < num_write_ports; i++) begin
      if (wb_ld[i] && wb_dest[i] != X0 && wb_dest[i] == hold.rs1) begin
        hit1 = 1'b1;
        byp1 = wb_data[i];
      end
      if (wb_ld[i] && wb_dest[i] != X0 && wb_dest[i] == hold.rs2) begin
        hit2 = 1'b1;
        byp2 = wb_data[i];
      end
    end
  end
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
  assign byp1 = '0;
  assign byp2 = '0;
`endif

  assign rdy1 = !live1 || !busy_rs1 || hit1;
  assign rdy2 = !live2 || !busy_rs2 || hit2;
  assign op1  = !live1 ? '0 : (hit1 ? byp1 : rf_out[0]);
  assign op2  = !live2 ? '0 : (hit2 ? byp2 : rf_out[1]);

  // Destination hazard is never forwarded: wait for the busy bit to actually clear.
  assign waw      = hold.wr_rd && hold.rd != X0 && busy_rd;
  assign issue    = hold.valid && rdy1 && rdy2 && !waw && (!out_valid || out_ready);
  assign in_ready = !hold.valid || issue;

  rrd_scoreboard #(
    .s_index         (s_index),
    .num_write_ports (num_write_ports)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set      (issue && hold.wr_rd && hold.rd != X0),
    .set_idx  (hold.rd),
    .clr      (wb_ld),
    .clr_idx  (wb_dest),
    .q_rs1    (hold.rs1),
    .q_rs2    (hold.rs2),
    .q_rd     (hold.rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      out_valid   <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_wr_rd   <= 1'b0;
      out_payload <= '0;
    end else begin
      if (in_valid && in_ready) begin
        hold <= '{valid: 1'b1, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                  use_rs1: in_use_rs1, use_rs2: in_use_rs2, wr_rd: in_wr_rd,
                  payload: in_payload};
      end else if (issue) begin
        hold.valid <= 1'b0;
      end

      if (issue) begin
        out_valid   <= 1'b1;
        out_op1     <= op1;
        out_op2     <= op2;
        out_rd      <= hold.rd;
        out_wr_rd   <= hold.wr_rd;
        out_payload <= hold.payload;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
